// File: rtl/buttons.sv
// buttons -- five-input button debouncer with a small register block.
// Raw button levels are synchronised, filtered on a 1 ms tick, and their
// debounced edges latch into sticky PRESS/RELEASE registers. Software
// reads and clears them over a simple sel/ready bus.
// Optional feature: define BUTTONS_IRQ_EN to add a writable IRQ_MASK at
// offset 3 and a registered irq_out = |(PRESS & IRQ_MASK).
module buttons #(
  parameter int BASETIME    = 12000000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  buttons_in,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out
`ifdef BUTTONS_IRQ_EN
  ,
  output logic        irq_out
`endif
);

  // Tick period in clock cycles; clamped so tiny BASETIME values still tick.
  localparam int TICK_PERIOD = ((BASETIME / 1000) > 0) ? (BASETIME / 1000) : 1;
  localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);

  // A level must disagree for DEB_LIMIT consecutive ticks to be accepted.
  localparam int DEB_LIMIT = (DEBOUNCE_MS > 0) ? DEBOUNCE_MS : 1;
  localparam int DEB_W     = $clog2(DEB_LIMIT + 1);
  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEB_LIMIT);

  // Register offsets, selected by address_in[3:2].
  localparam logic [1:0] REG_STATE    = 2'd0;
  localparam logic [1:0] REG_PRESS    = 2'd1;
  localparam logic [1:0] REG_RELEASE  = 2'd2;
  localparam logic [1:0] REG_IRQ_MASK = 2'd3;

  // Synchroniser stages
  logic [4:0] sync1_q, sync1_d;
  logic [4:0] sync2_q, sync2_d;

  // Millisecond tick generator
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  // Debounce state: per-bit stability counters and accepted levels
  logic [DEB_W-1:0] stab_q [5];
  logic [DEB_W-1:0] stab_d [5];
  logic [DEB_W-1:0] stab_inc;
  logic [4:0]       deb_q, deb_d;
  logic [4:0]       rise, fall;

  // Sticky edge registers
  logic [4:0] press_q, press_d;
  logic [4:0] release_q, release_d;
  logic [4:0] press_clr, release_clr;

  // Bus side
  logic        access;
  logic        rd_en;
  logic        wr_en;
  logic [1:0]  reg_sel;
  logic [4:0]  reg_rdata;
  logic [31:0] read_value_q, read_value_d;
  logic        ready_q, ready_d;

`ifdef BUTTONS_IRQ_EN
  logic [4:0] irq_mask_q, irq_mask_d;
  logic       irq_q, irq_d;
`endif

  // Only address bits [3:2], mask bit 0 and data bits [4:0] carry meaning.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{address_in[31:4], address_in[1:0],
                             write_mask_in[3:1], write_value_in[31:5]};

  // Two-flop synchroniser: stage one samples the pins, stage two resamples it.
  always_comb begin
    sync1_d = buttons_in;
    sync2_d = sync1_q;
  end

  // Free-running tick counter; pulses for one cycle and wraps to zero.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : (tick_cnt_q + TICK_W'(1));
  end

  // Per-bit stability filter, evaluated only on ticks.
  always_comb begin
    deb_d    = deb_q;
    stab_inc = '0;
    for (int i = 0; i < 5; i++) begin
      stab_d[i] = stab_q[i];
      if (tick) begin
        if (sync2_q[i] == deb_q[i]) begin
          stab_d[i] = '0;
        end else begin
          stab_inc = stab_q[i] + DEB_W'(1);
          if (stab_inc == DEB_TARGET) begin
            deb_d[i]  = sync2_q[i];
            stab_d[i] = '0;
          end else begin
            stab_d[i] = stab_inc;
          end
        end
      end
    end
  end

  // Debounced edge detection, aligned with the cycle the level is accepted.
  always_comb begin
    rise = deb_d & ~deb_q;
    fall = deb_q & ~deb_d;
  end

  // Bus front end: take a new access whenever selected and not completing one.
  always_comb begin
    access  = sel_in & ~ready_q;
    reg_sel = address_in[3:2];
    rd_en   = access & read_in;
    wr_en   = access & ~read_in & write_mask_in[0];
  end

  // Read multiplexer over the current register contents.
  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      REG_STATE:    reg_rdata = deb_q;
      REG_PRESS:    reg_rdata = press_q;
      REG_RELEASE:  reg_rdata = release_q;
`ifdef BUTTONS_IRQ_EN
      REG_IRQ_MASK: reg_rdata = irq_mask_q;
`else
      REG_IRQ_MASK: reg_rdata = '0;
`endif
    endcase
  end

  // Write-one-to-clear masks for the sticky registers; STATE is read-only.
  always_comb begin
    press_clr   = '0;
    release_clr = '0;
    if (wr_en && (reg_sel == REG_PRESS)) begin
      press_clr = write_value_in[4:0];
    end
    if (wr_en && (reg_sel == REG_RELEASE)) begin
      release_clr = write_value_in[4:0];
    end
  end

  // Sticky updates: a fresh edge wins over a same-cycle clear of that bit.
  always_comb begin
    press_d      = (press_q & ~press_clr) | rise;
    release_d    = (release_q & ~release_clr) | fall;
    read_value_d = rd_en ? {27'd0, reg_rdata} : read_value_q;
    ready_d      = access;
  end

`ifdef BUTTONS_IRQ_EN
  // Interrupt mask write path and registered interrupt request.
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_en && (reg_sel == REG_IRQ_MASK)) begin
      irq_mask_d = write_value_in[4:0];
    end
    irq_d = |(press_q & irq_mask_q);
  end

  // Interrupt state flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_out = irq_q;
`endif

  // All remaining state flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      tick_cnt_q   <= '0;
      deb_q        <= '0;
      press_q      <= '0;
      release_q    <= '0;
      read_value_q <= '0;
      ready_q      <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        stab_q[i] <= '0;
      end
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_cnt_q   <= tick_cnt_d;
      deb_q        <= deb_d;
      press_q      <= press_d;
      release_q    <= release_d;
      read_value_q <= read_value_d;
      ready_q      <= ready_d;
      for (int i = 0; i < 5; i++) begin
        stab_q[i] <= stab_d[i];
      end
    end
  end

  assign read_value_out = read_value_q;
  assign ready_out      = ready_q;

endmodule

// File: tb/tb_buttons.sv
// tb_buttons -- directed plus randomized bench for the buttons peripheral.
// Expected values come from spec-level constants and from a cycle-based
// behavioural model (edge counting, integer run lengths).
module tb_buttons;

  localparam int BASETIME    = 4000;
  localparam int DEBOUNCE_MS = 3;
  localparam int TICK_CYCLES = BASETIME / 1000;

  localparam logic [1:0] REG_STATE    = 2'd0;
  localparam logic [1:0] REG_PRESS    = 2'd1;
  localparam logic [1:0] REG_RELEASE  = 2'd2;
  localparam logic [1:0] REG_IRQ_MASK = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  buttons_in = '0;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic        ready_out;
`ifdef BUTTONS_IRQ_EN
  logic        irq_out;
`endif

  int total = 0;
  int bad = 0;

  buttons #(
    .BASETIME(BASETIME),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .buttons_in(buttons_in),
    .address_in(address_in),
    .sel_in(sel_in),
    .read_in(read_in),
    .read_value_out(read_value_out),
    .write_mask_in(write_mask_in),
    .write_value_in(write_value_in),
    .ready_out(ready_out)
`ifdef BUTTONS_IRQ_EN
    ,
    .irq_out(irq_out)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model state: input history, edges since reset, run lengths.
  logic [4:0]  ref_hist1 = '0;
  logic [4:0]  ref_hist2 = '0;
  logic [4:0]  ref_level = '0;
  logic [4:0]  ref_press = '0;
  logic [4:0]  ref_release = '0;
  int          ref_run [5] = '{default: 0};
  int          ref_edges = 0;
  logic        ref_ready = 1'b0;
  logic [31:0] ref_rdata = '0;
`ifdef BUTTONS_IRQ_EN
  logic [4:0]  ref_mask = '0;
  logic        ref_irq = 1'b0;
  logic [4:0]  nx_mask;
  logic        nx_irq;
`endif

  logic        ref_accept;
  logic        ref_tick;
  logic [4:0]  ref_view;
  logic [4:0]  ref_clr_press;
  logic [4:0]  ref_clr_release;
  logic [4:0]  nx_level, nx_press, nx_release;
  int          nx_run [5];
  logic        nx_ready;
  logic [31:0] nx_rdata;

  // Model next-state: what the peripheral should hold after the coming edge.
  always_comb begin
    ref_accept = sel_in && !ref_ready;
    ref_tick   = ((ref_edges + 1) % TICK_CYCLES) == 0;
    case (address_in[3:2])
      REG_STATE:   ref_view = ref_level;
      REG_PRESS:   ref_view = ref_press;
      REG_RELEASE: ref_view = ref_release;
`ifdef BUTTONS_IRQ_EN
      default:     ref_view = ref_mask;
`else
      default:     ref_view = 5'd0;
`endif
    endcase
    nx_ready = ref_accept;
    nx_rdata = (ref_accept && read_in) ? {27'd0, ref_view} : ref_rdata;
    ref_clr_press = 5'd0;
    ref_clr_release = 5'd0;
`ifdef BUTTONS_IRQ_EN
    nx_mask = ref_mask;
    nx_irq  = |(ref_press & ref_mask);
`endif
    if (ref_accept && !read_in && write_mask_in[0]) begin
      if (address_in[3:2] == REG_PRESS)   ref_clr_press = write_value_in[4:0];
      if (address_in[3:2] == REG_RELEASE) ref_clr_release = write_value_in[4:0];
`ifdef BUTTONS_IRQ_EN
      if (address_in[3:2] == REG_IRQ_MASK) nx_mask = write_value_in[4:0];
`endif
    end
    nx_level   = ref_level;
    nx_press   = ref_press & ~ref_clr_press;
    nx_release = ref_release & ~ref_clr_release;
    for (int i = 0; i < 5; i++) begin
      nx_run[i] = ref_run[i];
      if (ref_tick) begin
        if (ref_hist2[i] == ref_level[i]) begin
          nx_run[i] = 0;
        end else if (ref_run[i] + 1 >= DEBOUNCE_MS) begin
          nx_run[i] = 0;
          nx_level[i] = ref_hist2[i];
          if (ref_hist2[i]) nx_press[i] = 1'b1;
          else nx_release[i] = 1'b1;
        end else begin
          nx_run[i] = ref_run[i] + 1;
        end
      end
    end
  end

  // Model state advance on every clock edge.
  always @(posedge clk) begin
    if (reset) begin
      ref_hist1 <= '0;
      ref_hist2 <= '0;
      ref_level <= '0;
      ref_press <= '0;
      ref_release <= '0;
      ref_edges <= 0;
      ref_ready <= 1'b0;
      ref_rdata <= '0;
      for (int i = 0; i < 5; i++) ref_run[i] <= 0;
`ifdef BUTTONS_IRQ_EN
      ref_mask <= '0;
      ref_irq <= 1'b0;
`endif
    end else begin
      ref_hist1 <= buttons_in;
      ref_hist2 <= ref_hist1;
      ref_level <= nx_level;
      ref_press <= nx_press;
      ref_release <= nx_release;
      ref_edges <= ref_edges + 1;
      ref_ready <= nx_ready;
      ref_rdata <= nx_rdata;
      for (int i = 0; i < 5; i++) ref_run[i] <= nx_run[i];
`ifdef BUTTONS_IRQ_EN
      ref_mask <= nx_mask;
      ref_irq <= nx_irq;
`endif
    end
  end

  // Drive the bus inputs; unused address and data bits get random filler.
  task automatic applyStimulus(input logic sel, input logic rd, input logic [1:0] reg_idx,
                               input logic [3:0] mask, input logic [31:0] value);
    logic [31:0] filler;
    filler = $urandom();
    sel_in = sel;
    read_in = rd;
    address_in = {filler[31:4], reg_idx, filler[1:0]};
    write_mask_in = mask;
    write_value_in = value;
  endtask

  // One comparison: count it, and report on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Single access starting at a negedge with ready_out low; ends two cycles later.
  task automatic busAccess(input string tag, input logic rd, input logic [1:0] reg_idx,
                           input logic [3:0] mask, input logic [31:0] value, output logic [31:0] data);
    applyStimulus(1'b1, rd, reg_idx, mask, value);
    @(negedge clk);
    checkOutput({tag, "_ready"}, 32'(ready_out), 32'd1);
    if (rd) checkOutput({tag, "_model"}, read_value_out, ref_rdata);
    data = read_value_out;
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_idle"}, 32'(ready_out), 32'd0);
  endtask

  task automatic readReg(input string tag, input logic [1:0] reg_idx, input logic [31:0] expected);
    logic [31:0] data;
    busAccess(tag, 1'b1, reg_idx, 4'd0, 32'd0, data);
    checkOutput({tag, "_value"}, data, expected);
  endtask

  task automatic writeReg(input string tag, input logic [1:0] reg_idx, input logic [3:0] mask,
                          input logic [31:0] value);
    logic [31:0] data;
    busAccess(tag, 1'b0, reg_idx, mask, value, data);
  endtask

  // Two reset cycles with the given buttons held; returns at the negedge before edge 1.
  task automatic doReset(input logic [4:0] held);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
    buttons_in = held;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 32'(ready_out), 32'd0);
    checkOutput("reset_rdata", read_value_out, 32'd0);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] data;
    int waited;
    $display("[TB] buttons bench start");

    // Reset state
    doReset(5'b00000);
    readReg("rst_state", REG_STATE, 32'h0);
    readReg("rst_press", REG_PRESS, 32'h0);
    readReg("rst_release", REG_RELEASE, 32'h0);

    // Steady press, then release
    buttons_in = 5'b00001;
    repeat (20) @(negedge clk);
    readReg("hold_state", REG_STATE, 32'h1);
    readReg("hold_press", REG_PRESS, 32'h1);
    readReg("hold_release", REG_RELEASE, 32'h0);
    buttons_in = 5'b00000;
    repeat (20) @(negedge clk);
    readReg("rel_state", REG_STATE, 32'h0);
    readReg("rel_release", REG_RELEASE, 32'h1);
    readReg("rel_press", REG_PRESS, 32'h1);

    // Bouncing input never settles long enough
    doReset(5'b00000);
    for (int k = 0; k < 12; k++) begin
      buttons_in[1] = ~buttons_in[1];
      repeat (5) @(negedge clk);
    end
    readReg("bounce_state", REG_STATE, 32'h0);
    readReg("bounce_press", REG_PRESS, 32'h0);

    // Write-one-to-clear honours mask bit 0; STATE is read-only
    doReset(5'b00000);
    buttons_in = 5'b00001;
    repeat (20) @(negedge clk);
    writeReg("w1c_nomask", REG_PRESS, 4'b0000, 32'h1);
    readReg("w1c_nomask_press", REG_PRESS, 32'h1);
    writeReg("w1c_mask", REG_PRESS, 4'b0001, 32'h1);
    readReg("w1c_mask_press", REG_PRESS, 32'h0);
    writeReg("state_wr", REG_STATE, 4'b0001, 32'h1e);
    readReg("state_wr_state", REG_STATE, 32'h1);
    writeReg("mask_wr", REG_IRQ_MASK, 4'b0001, 32'hffff_ff1f);
`ifdef BUTTONS_IRQ_EN
    readReg("mask_rd", REG_IRQ_MASK, 32'h1f);
`else
    readReg("mask_rd", REG_IRQ_MASK, 32'h0);
`endif

    // Back-to-back reads with sel held high: STATE, RELEASE, STATE
    applyStimulus(1'b1, 1'b1, REG_STATE, 4'd0, 32'd0);
    checkOutput("b2b_ready_0", 32'(ready_out), 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_1", 32'(ready_out), 32'd1);
    checkOutput("b2b_data_1", read_value_out, 32'h1);
    applyStimulus(1'b1, 1'b1, REG_RELEASE, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_2", 32'(ready_out), 32'd0);
    checkOutput("b2b_hold_2", read_value_out, 32'h1);
    @(negedge clk);
    checkOutput("b2b_ready_3", 32'(ready_out), 32'd1);
    checkOutput("b2b_data_3", read_value_out, 32'h0);
    applyStimulus(1'b1, 1'b1, REG_STATE, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_4", 32'(ready_out), 32'd0);
    @(negedge clk);
    checkOutput("b2b_ready_5", 32'(ready_out), 32'd1);
    checkOutput("b2b_data_5", read_value_out, 32'h1);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("b2b_idle", 32'(ready_out), 32'd0);

    // Reset during an in-flight access, button held through reset
    applyStimulus(1'b1, 1'b1, REG_STATE, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("abort_ready_pre", 32'(ready_out), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready_rst", 32'(ready_out), 32'd0);
    checkOutput("abort_rdata_rst", read_value_out, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready_post", 32'(ready_out), 32'd0);
    readReg("held_early", REG_PRESS, 32'h0);
    repeat (5) @(negedge clk);
    readReg("held_mid", REG_PRESS, 32'h0);
    repeat (10) @(negedge clk);
    readReg("held_late_press", REG_PRESS, 32'h1);
    readReg("held_late_state", REG_STATE, 32'h1);

    // Clear of PRESS[2] accepted on the very edge its debounced rise lands (edge 12)
    doReset(5'b00100);
    repeat (11) @(negedge clk);
    writeReg("collide", REG_PRESS, 4'b0001, 32'h4);
    readReg("collide_press", REG_PRESS, 32'h4);

`ifdef BUTTONS_IRQ_EN
    // Interrupt follows PRESS & IRQ_MASK one cycle later
    doReset(5'b00000);
    writeReg("irq_mask", REG_IRQ_MASK, 4'b0001, 32'h4);
    buttons_in = 5'b00100;
    waited = 0;
    while (!ref_press[2] && waited < 40) begin
      @(negedge clk);
      checkOutput("irq_track", 32'(irq_out), 32'(ref_irq));
      waited++;
    end
    checkOutput("irq_wait_press", 32'(waited < 40), 32'd1);
    checkOutput("irq_same_cycle", 32'(irq_out), 32'd0);
    @(negedge clk);
    checkOutput("irq_set", 32'(irq_out), 32'd1);
    applyStimulus(1'b1, 1'b0, REG_PRESS, 4'b0001, 32'h4);
    @(negedge clk);
    checkOutput("irq_clear_edge", 32'(irq_out), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'd0, 32'd0);
    @(negedge clk);
    checkOutput("irq_cleared", 32'(irq_out), 32'd0);
`endif

    // Randomized buttons and bus traffic against the model
    doReset(5'b00000);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) buttons_in = 5'($urandom());
      repeat ($urandom_range(1, 15)) @(negedge clk);
      busAccess("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                4'($urandom()), $urandom(), data);
    end
    busAccess("final_state", 1'b1, REG_STATE, 4'd0, 32'd0, data);
    busAccess("final_press", 1'b1, REG_PRESS, 4'd0, 32'd0, data);
    busAccess("final_release", 1'b1, REG_RELEASE, 4'd0, 32'd0, data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buttons.md
BUTTONS -- requirements
Module: buttons

Interface
REQ-001 SHALL have parameter BASETIME, default 12000000, clock cycles per second.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, consecutive 1 ms ticks an input must hold a new level before it is accepted.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port buttons_in  input  5  raw asynchronous button levels, 1 = pressed.
REQ-006 SHALL have port address_in  input  32  bus address; only bits [3:2] decoded.
REQ-007 SHALL have port sel_in  input  1  bus select for this peripheral.
REQ-008 SHALL have port read_in  input  1  1 = read access, 0 = write access.
REQ-009 SHALL have port read_value_out  output  32  registered read data.
REQ-010 SHALL have port write_mask_in  input  4  byte enables; only bit 0 (data bits [7:0]) used.
REQ-011 SHALL have port write_value_in  input  32  write data.
REQ-012 SHALL have port ready_out  output  1  registered access-complete strobe.

Function
REQ-013 SHALL pass each buttons_in bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL generate a 1-cycle tick every BASETIME/1000 cycles from a free-running counter that wraps to 0 on the tick.
REQ-015 SHALL keep a per-bit stability counter: on a tick, cleared if synced bit equals debounced bit, else incremented; the debounced bit takes the synced value and the counter clears when the increment reaches DEBOUNCE_MS.
REQ-016 SHALL set PRESS[i] on a debounced 0->1 transition and RELEASE[i] on a debounced 1->0 transition; bits stay set until cleared.
REQ-017 SHALL map registers by address_in[3:2]: 0 STATE (debounced levels, read-only), 1 PRESS (write-1-to-clear), 2 RELEASE (write-1-to-clear), 3 IRQ_MASK (see Configuration).
REQ-018 SHALL return register data in read_value_out[4:0], bits [31:5] zero.
REQ-019 SHALL accept an access in any cycle where sel_in=1 and ready_out=0; ready_out SHALL be 1 exactly in the following cycle, then 0.
REQ-020 SHALL load read_value_out on an accepted read and hold it until the next accepted read.
REQ-021 SHALL perform an accepted write only if read_in=0 and write_mask_in[0]=1; otherwise no state change; writes to STATE ignored.
REQ-022 SHALL give a set from a new edge priority over a simultaneous write-1-to-clear of the same bit.
REQ-023 SHALL, with sel_in held high, complete back-to-back accesses every 2 cycles.
REQ-024 SHALL ignore accepted accesses' effect on debounce timing (bus and debounce fully independent).

Reset
REQ-025 SHALL on reset clear synchronizers, tick counter, stability counters, debounced state, PRESS, RELEASE, IRQ_MASK, read_value_out and ready_out to 0.
REQ-026 SHALL abort an in-flight access on reset: ready_out 0 in the cycle after reset deasserts unless a new access is accepted.
REQ-027 SHALL not report edges for buttons held pressed through reset until DEBOUNCE_MS ticks after reset release, then set PRESS.

Configuration
REQ-028 SHALL with macro BUTTONS_IRQ_EN defined add output irq_out (1 bit), a writable IRQ_MASK[4:0] at offset 3, and drive irq_out registered as OR of (PRESS & IRQ_MASK), reset 0.
REQ-029 SHALL without BUTTONS_IRQ_EN omit irq_out, read offset 3 as 0 and ignore writes to it.

Verification (BASETIME=4000 -> tick every 4 cycles, DEBOUNCE_MS=3)
REQ-030 SHALL check: buttons_in=5'b00001 held 20 cycles -> STATE reads 0x1, PRESS reads 0x1, RELEASE 0x0.
REQ-031 SHALL check: buttons_in[1] toggled every 5 cycles for 60 cycles -> STATE, PRESS stay 0x0.
REQ-032 SHALL check: press then write 0x1 to offset 1 with mask 4'b0001 -> PRESS reads 0x0; same write with mask 4'b0000 -> PRESS stays 0x1.
REQ-033 SHALL check: sel_in held high, read_in=1, three reads -> ready_out pattern 0,1,0,1,0,1 and each read_value_out valid while ready_out=1.
REQ-034 SHALL check: W1C of PRESS[2] in the same cycle a new button-2 press is accepted -> PRESS[2] remains 1.
REQ-035 SHALL check (BUTTONS_IRQ_EN): IRQ_MASK=0x4, press button 2 -> irq_out 1 one cycle after PRESS[2] sets; clear PRESS[2] -> irq_out 0 next cycle.
